// File: rtl/md_seq_if.sv
// md_seq_if: EX-stage <-> multiply/divide sequencer bundle.
// The master side is the EX stage (operands, op select, mfhi/mflo requests).
// The slave side is md_seq, which returns HI/LO, busy, done and stall.
interface md_seq_if;
  logic        flush;
  logic        start;
  logic [2:0]  func;
  logic        is_sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hi;
  logic        rd_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output flush, start, func, is_sign, a, b, rd_hi, rd_lo,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  flush, start, func, is_sign, a, b, rd_hi, rd_lo,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/md_seq.sv
// md_seq: multi-cycle multiply/divide sequencer owning the HI/LO registers.
// mult/multu run for MUL_LAT cycles, div/divu use a 32-step radix-2
// restoring divider on magnitudes with a final sign correction.
// Optional build macro MD_FAST_MUL_EN: mult/multu complete at the start edge
// (no busy, no stall); divide is unchanged.
module md_seq #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic    clk,
  input  logic    rst,
  md_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  localparam logic [4:0] DIV_CNT_INIT = 5'(DIV_LAT - 1);
`ifndef MD_FAST_MUL_EN
  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);
`endif

  // Conditional two's-complement negate used for magnitudes and sign fix-up.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t      state_r, state_nxt;
  logic [4:0]  cnt_r, cnt_nxt;
  logic [31:0] hi_r, hi_nxt;
  logic [31:0] lo_r, lo_nxt;
  logic [31:0] op_a_r, op_a_nxt;   // mult operand a / original dividend
  logic [31:0] op_b_r, op_b_nxt;   // mult operand b / divisor magnitude
  logic [31:0] rem_r, rem_nxt;
  logic [31:0] quo_r, quo_nxt;
  logic        sign_r, sign_nxt;
  logic        q_neg_r, q_neg_nxt;
  logic        r_neg_r, r_neg_nxt;
  logic        busy_r, busy_nxt;
  logic        done_r, done_nxt;

  logic [31:0] mul_a_s, mul_b_s;
  logic        mul_sign_s;
  logic [63:0] mul_a_ext_s, mul_b_ext_s, prod_s;
  logic [32:0] rem_sh_s;
  logic [33:0] trial_s;
  logic        step_ok_s;
  logic [31:0] rem_step_s, quo_step_s;
  logic        div_sa_s, div_sb_s;

  assign div_sa_s = bus.is_sign & bus.a[31];
  assign div_sb_s = bus.is_sign & bus.b[31];

  // Full 64-bit product, sign-extended operands give the signed result mod 2^64.
  always_comb begin
`ifdef MD_FAST_MUL_EN
    mul_a_s    = bus.a;
    mul_b_s    = bus.b;
    mul_sign_s = bus.is_sign;
`else
    mul_a_s    = op_a_r;
    mul_b_s    = op_b_r;
    mul_sign_s = sign_r;
`endif
    if (mul_sign_s) begin
      mul_a_ext_s = {{32{mul_a_s[31]}}, mul_a_s};
      mul_b_ext_s = {{32{mul_b_s[31]}}, mul_b_s};
    end else begin
      mul_a_ext_s = {32'd0, mul_a_s};
      mul_b_ext_s = {32'd0, mul_b_s};
    end
    prod_s = mul_a_ext_s * mul_b_ext_s;
  end

  // One restoring step: shift rem:quo left, trial-subtract divisor, set quotient bit.
  always_comb begin
    rem_sh_s  = {rem_r, quo_r[31]};
    trial_s   = {1'b0, rem_sh_s} - {2'b00, op_b_r};
    step_ok_s = ~trial_s[33];
    if (step_ok_s) begin
      rem_step_s = trial_s[31:0];
    end else begin
      rem_step_s = rem_sh_s[31:0];
    end
    quo_step_s = {quo_r[30:0], step_ok_s};
  end

  // Next-state and datapath decisions; flush beats start and aborts without writes.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    hi_nxt    = hi_r;
    lo_nxt    = lo_r;
    op_a_nxt  = op_a_r;
    op_b_nxt  = op_b_r;
    rem_nxt   = rem_r;
    quo_nxt   = quo_r;
    sign_nxt  = sign_r;
    q_neg_nxt = q_neg_r;
    r_neg_nxt = r_neg_r;
    done_nxt  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.func)
            3'd1: begin
`ifdef MD_FAST_MUL_EN
              {hi_nxt, lo_nxt} = prod_s;
              done_nxt         = 1'b1;
`else
              op_a_nxt  = bus.a;
              op_b_nxt  = bus.b;
              sign_nxt  = bus.is_sign;
              cnt_nxt   = MUL_CNT_INIT;
              state_nxt = ST_MUL;
`endif
            end
            3'd2: begin
              op_a_nxt  = bus.a;
              op_b_nxt  = neg_if(bus.b, div_sb_s);
              quo_nxt   = neg_if(bus.a, div_sa_s);
              rem_nxt   = 32'd0;
              q_neg_nxt = div_sa_s ^ div_sb_s;
              r_neg_nxt = div_sa_s;
              cnt_nxt   = DIV_CNT_INIT;
              state_nxt = ST_DIV;
            end
            3'd3: hi_nxt = bus.a;
            3'd4: lo_nxt = bus.a;
            default: state_nxt = ST_IDLE;
          endcase
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (bus.flush) begin
          state_nxt = ST_IDLE;
        end else if (cnt_r == 5'd0) begin
          {hi_nxt, lo_nxt} = prod_s;
          done_nxt         = 1'b1;
          state_nxt        = ST_IDLE;
        end else begin
          cnt_nxt = cnt_r - 5'd1;
        end
      end
      ST_DIV: begin
        if (bus.flush) begin
          state_nxt = ST_IDLE;
        end else begin
          rem_nxt = rem_step_s;
          quo_nxt = quo_step_s;
          if (cnt_r == 5'd0) begin
            if (op_b_r == 32'd0) begin
              lo_nxt = 32'hFFFF_FFFF;
              hi_nxt = op_a_r;
            end else begin
              lo_nxt = neg_if(quo_step_s, q_neg_r);
              hi_nxt = neg_if(rem_step_s, r_neg_r);
            end
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt_r - 5'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      op_a_r  <= 32'd0;
      op_b_r  <= 32'd0;
      rem_r   <= 32'd0;
      quo_r   <= 32'd0;
      sign_r  <= 1'b0;
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      hi_r    <= hi_nxt;
      lo_r    <= lo_nxt;
      op_a_r  <= op_a_nxt;
      op_b_r  <= op_b_nxt;
      rem_r   <= rem_nxt;
      quo_r   <= quo_nxt;
      sign_r  <= sign_nxt;
      q_neg_r <= q_neg_nxt;
      r_neg_r <= r_neg_nxt;
      busy_r  <= busy_nxt;
      done_r  <= done_nxt;
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.stall = busy_r & (bus.start | bus.rd_hi | bus.rd_lo);

endmodule
